// File: rtl/or8way_bist.sv
// Built-in self-test engine for the Or8Way reduction chip: sweeps all 256 input
// vectors, compares the sampled result with the OR reference and reports errors.
module or8way_bist #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail_vec,
  output logic       first_fail_valid,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // WAIT counts down from SETTLE_CYCLES-1 and exits on zero, giving exactly
  // SETTLE_CYCLES cycles in WAIT.
  localparam bit         HAS_WAIT  = (SETTLE_CYCLES != 0);
  localparam logic [3:0] WAIT_LOAD = 4'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

  state_t     state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [3:0] wait_q, wait_d;
  logic [8:0] err_q, err_d;
  logic [7:0] ffv_q, ffv_d;
  logic       ffval_q, ffval_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= 8'd0;
      wait_q  <= 4'd0;
      err_q   <= 9'd0;
      ffv_q   <= 8'd0;
      ffval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DRIVE;
          vec_d   = 8'd0;
          err_d   = 9'd0;
          ffv_d   = 8'd0;
          ffval_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (HAS_WAIT) begin
          state_d = ST_WAIT;
          wait_d  = WAIT_LOAD;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) state_d = ST_CHECK;
        else                wait_d  = wait_q - 4'd1;
      end
      ST_CHECK: begin
        // dut_out is only looked at here, so an undriven DUT cannot leak X elsewhere.
        if (dut_out != (|vec_q)) begin
          err_d = err_q + 9'd1;
          if (!ffval_q) begin
            ffv_d   = vec_q;
            ffval_d = 1'b1;
          end
        end
        if (vec_q == 8'hFF) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 8'd1;
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy             = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign done             = (state_q == ST_DONE);
  assign pass             = done && (err_q == 9'd0);
  assign dut_in           = busy ? vec_q : 8'd0;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_or8way_bist.sv
// Self-checking bench for or8way_bist: two instances (settle 1 and settle 0)
// driven against modelled good/faulty Or8Way devices and a cycle-level model.
module tb_or8way_bist;

  localparam int ST_IDLE  = 0;
  localparam int ST_DRIVE = 1;
  localparam int ST_WAIT  = 2;
  localparam int ST_CHECK = 3;
  localparam int ST_DONE  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  int   mode;              // 0 good, 1 stuck-0, 2 stuck-1, 3 and8, 4 good xor flip table
  logic flip [256];

  logic [7:0] din   [2];
  logic       dout  [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [8:0] errc  [2];
  logic [7:0] ffv   [2];
  logic       ffval [2];
  logic [2:0] dst   [2];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic dut_fn(input logic [7:0] v, input int m, input logic f);
    case (m)
      0:       return |v;
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return &v;
      default: return (|v) ^ f;
    endcase
  endfunction

  assign dout[0] = dut_fn(din[0], mode, flip[din[0]]);
  assign dout[1] = dut_fn(din[1], mode, flip[din[1]]);

  or8way_bist #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .reset(reset), .start(start), .dut_in(din[0]), .dut_out(dout[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
    .first_fail_vec(ffv[0]), .first_fail_valid(ffval[0]), .dbg_state(dst[0])
  );

  or8way_bist #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .reset(reset), .start(start), .dut_in(din[1]), .dut_out(dout[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
    .first_fail_vec(ffv[1]), .first_fail_valid(ffval[1]), .dbg_state(dst[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: phase 0 idle, 1 running, 2 done; t counts edges since the
  // start edge (t=1 on the start edge itself). Each vector spans L = 2+S edges.
  int m_ph    [2] = '{0, 0};
  int m_t     [2] = '{0, 0};
  int m_err   [2] = '{0, 0};
  int m_ffv   [2] = '{0, 0};
  int m_ffval [2] = '{0, 0};
  bit model_on = 1'b0;

  function automatic int s_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  always begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int L;
      L = 2 + s_of(k);
      if (reset) begin
        m_ph[k] = 0; m_t[k] = 0; m_err[k] = 0; m_ffv[k] = 0; m_ffval[k] = 0;
        model_on = 1'b1;
      end else if (m_ph[k] != 1 && start) begin
        m_ph[k] = 1; m_t[k] = 1; m_err[k] = 0; m_ffv[k] = 0; m_ffval[k] = 0;
      end else if (m_ph[k] == 1) begin
        if ((m_t[k] - 1) % L == L - 1) begin
          logic [7:0] cv;
          cv = 8'((m_t[k] - 1) / L);
          if (dut_fn(cv, mode, flip[cv]) != (|cv)) begin
            m_err[k]++;
            if (m_ffval[k] == 0) begin
              m_ffv[k]   = int'(cv);
              m_ffval[k] = 1;
            end
          end
        end
        if (m_t[k] == 256 * L) m_ph[k] = 2;
        else                   m_t[k]++;
      end
    end
    #1;
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        int L, c, p, e_din, e_busy, e_done, e_pass, e_st;
        string tag;
        L = 2 + s_of(k);
        tag = $sformatf("s%0d", s_of(k));
        c = (m_t[k] - 1) / L;
        p = (m_t[k] - 1) % L;
        case (m_ph[k])
          1: begin
            e_din = c; e_busy = 1; e_done = 0; e_pass = 0;
            e_st = (p == 0) ? ST_DRIVE : ((p == L - 1) ? ST_CHECK : ST_WAIT);
          end
          2: begin
            e_din = 0; e_busy = 0; e_done = 1; e_pass = (m_err[k] == 0) ? 1 : 0; e_st = ST_DONE;
          end
          default: begin
            e_din = 0; e_busy = 0; e_done = 0; e_pass = 0; e_st = ST_IDLE;
          end
        endcase
        check({tag, "_dut_in"},  int'(din[k]),   e_din);
        check({tag, "_busy"},    int'(busy[k]),  e_busy);
        check({tag, "_done"},    int'(done[k]),  e_done);
        check({tag, "_pass"},    int'(pass[k]),  e_pass);
        check({tag, "_state"},   int'(dst[k]),   e_st);
        check({tag, "_err"},     int'(errc[k]),  m_err[k]);
        check({tag, "_ffv"},     int'(ffv[k]),   m_ffv[k]);
        check({tag, "_ffvalid"}, int'(ffval[k]), m_ffval[k]);
      end
    end
  end

  // Driver tasks: all entered and left on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_both(output int e0, output int e1);
    int edge_n;
    edge_n = 1;
    e0 = 0;
    e1 = 0;
    while (!(done[0] && done[1]) && edge_n < 3000) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (done[0] && e0 == 0) e0 = edge_n;
      if (done[1] && e1 == 0) e1 = edge_n;
    end
    check("run_finished", int'(done[0] && done[1]), 1);
    @(negedge clk);
  endtask

  task automatic do_run(input int m, output int e0, output int e1);
    mode = m;
    pulse_start();
    wait_both(e0, e1);
  endtask

  initial begin
    int e0, e1, n, exp_err, exp_ffv;
    reset = 1'b1;
    start = 1'b0;
    mode  = 0;
    for (int i = 0; i < 256; i++) flip[i] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", int'(dst[0]), ST_IDLE);
    check("reset_busy",  int'(busy[0]), 0);
    check("reset_err",   int'(errc[0]), 0);

    // Good device: done edge and pass.
    do_run(0, e0, e1);
    check("s1_done_edge", e0, 769);
    check("s0_done_edge", e1, 513);
    check("good_pass",    int'(pass[0] && pass[1]), 1);
    check("good_err",     int'(errc[0]), 0);
    check("good_ffvalid", int'(ffval[0]), 0);
    check("good_dut_in",  int'(din[0]), 0);

    // Stuck-at-0, stuck-at-1, AND8.
    do_run(1, e0, e1);
    check("sa0_err",     int'(errc[0]), 255);
    check("sa0_ffv",     int'(ffv[0]), 1);
    check("sa0_ffvalid", int'(ffval[0]), 1);
    check("sa0_pass",    int'(pass[0]), 0);
    check("sa0_err_s0",  int'(errc[1]), 255);
    do_run(2, e0, e1);
    check("sa1_err", int'(errc[0]), 1);
    check("sa1_ffv", int'(ffv[0]), 0);
    do_run(3, e0, e1);
    check("and8_err", int'(errc[0]), 254);
    check("and8_ffv", int'(ffv[0]), 1);

    // Reset on edge 100 of a stuck-at-0 run, then a fresh full run.
    mode = 1;
    pulse_start();
    repeat (98) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state",   int'(dst[0]), ST_IDLE);
    check("abort_busy",    int'(busy[0]), 0);
    check("abort_done",    int'(done[0]), 0);
    check("abort_err",     int'(errc[0]), 0);
    check("abort_ffvalid", int'(ffval[0]), 0);
    check("abort_dut_in",  int'(din[0]), 0);
    do_run(1, e0, e1);
    check("rerun_done_edge", e0, 769);
    check("rerun_err",       int'(errc[0]), 255);

    // Start held high for the whole settle-1 run; ignored while busy.
    mode  = 1;
    start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!done[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_both(e0, e1);
    check("held_err", int'(errc[0]), 255);
    check("held_ffv", int'(ffv[0]), 1);

    // Swap in a good device and restart from DONE.
    mode = 0;
    pulse_start();
    check("restart_err_clear",     int'(errc[0]), 0);
    check("restart_ffvalid_clear", int'(ffval[0]), 0);
    check("restart_busy",          int'(busy[0]), 1);
    wait_both(e0, e1);
    check("restart_pass", int'(pass[0] && pass[1]), 1);

    // Every vector mismatching: the 256 boundary of err_count.
    for (int i = 0; i < 256; i++) flip[i] = 1'b1;
    do_run(4, e0, e1);
    check("all_err",  int'(errc[0]), 256);
    check("all_ffv",  int'(ffv[0]), 0);
    check("all_pass", int'(pass[0]), 0);

    // Random fault tables with random start chatter while busy.
    for (int r = 0; r < 3; r++) begin
      exp_err = 0;
      exp_ffv = -1;
      for (int i = 0; i < 256; i++) begin
        flip[i] = ($urandom_range(0, 7) == 0);
        if (flip[i]) begin
          exp_err++;
          if (exp_ffv < 0) exp_ffv = i;
        end
      end
      mode = 4;
      pulse_start();
      for (int i = 0; i < 150; i++) begin
        start = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
      start = 1'b0;
      wait_both(e0, e1);
      check("rand_err",  int'(errc[0]), exp_err);
      check("rand_pass", int'(pass[0]), (exp_err == 0) ? 1 : 0);
      if (exp_ffv >= 0) check("rand_ffv", int'(ffv[0]), exp_ffv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
